// File: rtl/async_mem_master.sv
// async_mem_master: valid/ready initiator for an asynchronous chip-select SRAM,
// sequencing cs/wr/rd strobes through programmable setup, pulse and hold phases.
module async_mem_master #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_mem_cs,
  output logic              o_mem_wr,
  output logic              o_mem_rd,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                                   : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              w_last, w_accept;
  logic              r_we, r_cs, r_wr, r_rd, r_rsp_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  // The counter holds the remaining cycles of the current phase; zero marks the phase's last cycle.
  always_comb begin
    w_last      = r_cnt == '0;
    w_accept    = r_state == IDLE && i_req_valid;
    w_state_nxt = r_state;
    w_cnt_nxt   = w_last ? '0 : r_cnt - CNT_W'(1);
    case (r_state)
      IDLE:   if (i_req_valid) begin w_state_nxt = SETUP;  w_cnt_nxt = CNT_W'(SETUP_CYC - 1); end
      SETUP:  if (w_last)      begin w_state_nxt = STROBE; w_cnt_nxt = CNT_W'(PULSE_CYC - 1); end
      STROBE: if (w_last)      begin w_state_nxt = HOLD;   w_cnt_nxt = CNT_W'(HOLD_CYC - 1);  end
      HOLD:   if (w_last)      w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end
  // Strobes are registered from the next state so they line up with cs without extra latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_cs        <= 1'b0;
      r_wr        <= 1'b0;
      r_rd        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rdata     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cs        <= w_state_nxt != IDLE;
      r_wr        <= w_state_nxt == STROBE && r_we;
      r_rd        <= w_state_nxt == STROBE && !r_we;
      r_rsp_valid <= r_state == HOLD && w_last;
      if (w_accept) begin
        r_we    <= i_req_we;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end
      if (r_state == STROBE && w_last && !r_we) r_rdata <= i_mem_rdata;
    end
  end
  assign o_req_ready = r_state == IDLE;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_rdata = r_rdata;
  assign o_mem_cs    = r_cs;
  assign o_mem_wr    = r_wr;
  assign o_mem_rd    = r_rd;
  assign o_mem_addr  = r_addr;
  assign o_mem_wdata = r_wdata;
endmodule

// File: tb/tb_async_mem_master.sv
// tb_async_mem_master: two instances (default and 2/1/3 timing) driven by directed and random
// requests, each output compared every cycle against a transaction-offset reference model.
module tb_async_mem_master;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic       vin[2], wein[2], rdy[2], cs[2], wr[2], rd[2], rv[2];
  logic [9:0] ain[2], ao[2];
  logic [7:0] din[2], wdo[2], rdo[2], mrd[2], noise[2];
  logic [7:0] mem[2][1024];
  logic [7:0] ref_mem[2][1024];
  int S[2] = '{1, 2};
  int P[2] = '{2, 1};
  int H[2] = '{1, 3};
  int cyc = 0;
  int n_vec = 0;
  int n_bad = 0;
  bit         act[2] = '{0, 0};
  int         tacc[2] = '{0, 0};
  bit         mwe[2] = '{0, 0};
  logic [9:0] maddr[2] = '{0, 0};
  logic [7:0] mdat[2] = '{0, 0};
  logic [7:0] erd[2] = '{0, 0};

  async_mem_master u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(vin[0]), .o_req_ready(rdy[0]), .i_req_we(wein[0]), .i_req_addr(ain[0]), .i_req_wdata(din[0]),
    .o_rsp_valid(rv[0]), .o_rsp_rdata(rdo[0]),
    .o_mem_cs(cs[0]), .o_mem_wr(wr[0]), .o_mem_rd(rd[0]), .o_mem_addr(ao[0]), .o_mem_wdata(wdo[0]),
    .i_mem_rdata(mrd[0])
  );
  async_mem_master #(.SETUP_CYC(2), .PULSE_CYC(1), .HOLD_CYC(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(vin[1]), .o_req_ready(rdy[1]), .i_req_we(wein[1]), .i_req_addr(ain[1]), .i_req_wdata(din[1]),
    .o_rsp_valid(rv[1]), .o_rsp_rdata(rdo[1]),
    .o_mem_cs(cs[1]), .o_mem_wr(wr[1]), .o_mem_rd(rd[1]), .o_mem_addr(ao[1]), .o_mem_wdata(wdo[1]),
    .i_mem_rdata(mrd[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic put(input int d, input bit v, input bit w, input logic [9:0] a, input logic [7:0] x);
    vin[d] = v; wein[d] = w; ain[d] = a; din[d] = x;
  endtask

  // memory drives garbage unless rd is asserted, so a mistimed sample is caught
  always_comb for (int d = 0; d < 2; d++) mrd[d] = rd[d] ? mem[d][ao[d]] : noise[d];
  always @(posedge clk) for (int d = 0; d < 2; d++) if (wr[d]) mem[d][ao[d]] <= wdo[d];
  always @(negedge clk) for (int d = 0; d < 2; d++) noise[d] <= 8'($urandom);

  // model: a transaction accepted on edge tacc occupies cycles tacc..tacc+L-1 with cs,
  // strobes on offsets S..S+P-1, response on offset L; memory updates/reads at edge offset S+P
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        act[d] <= 1'b0; erd[d] <= '0; maddr[d] <= '0; mdat[d] <= '0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (act[d] && cyc + 1 - tacc[d] == S[d] + P[d]) begin
          if (mwe[d]) ref_mem[d][maddr[d]] <= mdat[d];
          else erd[d] <= ref_mem[d][maddr[d]];
        end
        if (vin[d] && (!act[d] || cyc - tacc[d] >= S[d] + P[d] + H[d])) begin
          act[d] <= 1'b1; tacc[d] <= cyc + 1; mwe[d] <= wein[d]; maddr[d] <= ain[d]; mdat[d] <= din[d];
        end
      end
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int o, l, s, p;
      o = cyc - tacc[d];
      s = S[d];
      p = S[d] + P[d];
      l = S[d] + P[d] + H[d];
      if (!rst_n) begin
        check($sformatf("rst_cs%0d", d), cs[d], 0);
        check($sformatf("rst_wr%0d", d), wr[d], 0);
        check($sformatf("rst_rd%0d", d), rd[d], 0);
        check($sformatf("rst_rv%0d", d), rv[d], 0);
        check($sformatf("rst_rdata%0d", d), rdo[d], 0);
        check($sformatf("rst_addr%0d", d), ao[d], 0);
        check($sformatf("rst_wdata%0d", d), wdo[d], 0);
      end else begin
        check($sformatf("ready%0d", d), rdy[d], !act[d] || o >= l);
        check($sformatf("cs%0d", d), cs[d], act[d] && o < l);
        check($sformatf("wr%0d", d), wr[d], act[d] && mwe[d] && o >= s && o < p);
        check($sformatf("rd%0d", d), rd[d], act[d] && !mwe[d] && o >= s && o < p);
        check($sformatf("rsp_valid%0d", d), rv[d], act[d] && o == l);
        check($sformatf("rsp_rdata%0d", d), rdo[d], erd[d]);
        check($sformatf("mem_addr%0d", d), ao[d], maddr[d]);
        check($sformatf("mem_wdata%0d", d), wdo[d], mdat[d]);
      end
    end
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      put(d, 0, 0, '0, '0);
      for (int a = 0; a < 1024; a++) begin
        logic [7:0] v;
        v = (a == 0) ? 8'h00 : 8'($urandom);
        mem[d][a] <= v;
        ref_mem[d][a] <= v;
      end
    end
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("ready_after_reset", rdy[0], 1);
    // single write, read-back, then a write that must not disturb rsp_rdata
    put(0, 1, 1, 10'h155, 8'hA5); @(negedge clk); put(0, 0, 0, '0, '0); repeat (6) @(negedge clk);
    put(0, 1, 0, 10'h155, 8'h00); @(negedge clk); put(0, 0, 0, '0, '0); repeat (6) @(negedge clk);
    check("readback_0x155", rdo[0], 8'hA5);
    put(0, 1, 1, 10'h200, 8'h33); @(negedge clk); put(0, 0, 0, '0, '0); repeat (6) @(negedge clk);
    check("rdata_kept_after_write", rdo[0], 8'hA5);
    // back-to-back: read request held so it is taken in the write's response cycle
    put(0, 1, 1, 10'h3FF, 8'h5A); @(negedge clk);
    put(0, 1, 0, 10'h000, 8'hFF); repeat (5) @(negedge clk);
    put(0, 0, 0, '0, '0); repeat (7) @(negedge clk);
    // reset in the first strobe cycle of a write
    put(0, 1, 1, 10'h0AA, 8'hEE); @(negedge clk); put(0, 0, 0, '0, '0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_cs", cs[0], 0);
    check("midreset_wr", wr[0], 0);
    check("midreset_rv", rv[0], 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("ready_after_midreset", rdy[0], 1);
    put(0, 1, 0, 10'h0AA, 8'h00); @(negedge clk); put(0, 0, 0, '0, '0); repeat (6) @(negedge clk);
    // random traffic on both instances, including requests while busy
    repeat (800) begin
      for (int d = 0; d < 2; d++) begin
        int r;
        logic [9:0] a;
        r = $urandom_range(0, 7);
        a = (r == 0) ? 10'h000 : (r == 1) ? 10'h3FF : 10'($urandom_range(0, 15));
        put(d, $urandom_range(0, 2) != 0, 1'($urandom), a, 8'($urandom));
      end
      @(negedge clk);
    end
    put(0, 0, 0, '0, '0);
    put(1, 0, 0, '0, '0);
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
